fifo_read_ctrl: RTL

- Read-domain controller of the N-bit asynchronous FIFO; the downstream counterpart of the write-pointer stage.
- Brings the write-domain Gray write pointer into the read clock domain and decides when storage is empty.
- Drives the dual-port RAM read port, keeps the binary and Gray read pointers, and returns the Gray read pointer to the write side.
- Presents data first-word-fall-through (FWFT) with a valid/ready handshake, and reports fill level and almost-empty.

---
 rtl/fifo_read_ctrl.sv | 66 ++++++
 1 files changed

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-domain side of the async FIFO; syncs the write pointer, fetches from RAM and presents FWFT data
module fifo_read_ctrl #(
    parameter int pt     = 3,
    parameter int dw     = 8,
    parameter int ae_lvl = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [pt:0]   g_wrpt_async,
    input  logic [dw-1:0] mem_rdata,
    input  logic          rd_ready,
    output logic          mem_re,
    output logic [pt-1:0] mem_raddr,
    output logic [pt:0]   b_rdpt,
    output logic [pt:0]   g_rdpt,
    output logic [dw-1:0] rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          almost_empty,
    output logic [pt:0]   rd_count
);
    logic [pt:0] s1, g_wrpt_sync, b_wrpt_sync, ram_cnt, b_next;
    logic        pend, pop;

    for (genvar i = 0; i <= pt; i++) begin : g2b
        assign b_wrpt_sync[i] = ^g_wrpt_sync[pt:i];
    end

    assign ram_cnt      = b_wrpt_sync - b_rdpt;
    assign empty        = ram_cnt == '0;
    assign pop          = rd_valid & rd_ready;
    assign mem_re       = !empty & !pend & (!rd_valid | pop);
    assign mem_raddr    = b_rdpt[pt-1:0];
    assign b_next       = b_rdpt + (pt+1)'(1);
    assign rd_count     = ram_cnt + (pt+1)'(pend) + (pt+1)'(rd_valid);
    assign almost_empty = rd_count <= (pt+1)'(ae_lvl);

    // two-flop synchronizer for the write-domain Gray pointer
    always_ff @(posedge clk or posedge rst)
        if (rst) {g_wrpt_sync, s1} <= '0;
        else     {g_wrpt_sync, s1} <= {s1, g_wrpt_async};

    // read pointers advance at fetch time, releasing the slot to the writer
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            b_rdpt <= '0;
            g_rdpt <= '0;
        end else if (mem_re) begin
            b_rdpt <= b_next;
            g_rdpt <= b_next ^ (b_next >> 1);
        end

    // fetch in flight flag and FWFT output register
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pend     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            pend <= mem_re;
            if (pend) begin
                rd_data  <= mem_rdata;
                rd_valid <= 1'b1;
            end else if (pop) rd_valid <= 1'b0;
        end
endmodule
